vec_reg_file_masked: RTL

- Parametrised vector register file: NUM_REGS registers of LANES x LANE_W bits, two registered read ports, one lane-masked write port.
- Generalises the fixed 8 x 256-bit file. Adds per-lane write enables, write-first forwarding, and a post-reset clear sequencer with a ready indication.
- Sits between vector decode (read addresses) and vector writeback (write data/mask).

---
 rtl/vrf_pkg.sv | 18 +
 rtl/vrf_lane_merge.sv | 20 ++
 rtl/vec_reg_file_masked.sv | 103 ++++++++++
 3 files changed

// File: rtl/vrf_pkg.sv
// rtl/vrf_pkg.sv - shared constants, state encoding and lane helpers for the vector register file
package vrf_pkg;

  localparam int VRF_NUM_REGS = 8;
  localparam int VRF_LANES    = 16;
  localparam int VRF_LANE_W   = 16;

  typedef enum logic {
    VRF_CLEAR = 1'b0,
    VRF_RUN   = 1'b1
  } vrf_state_e;

  // Bit offset of the least significant bit of a lane within a packed vector.
  function automatic int lane_lsb(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/vrf_lane_merge.sv
// rtl/vrf_lane_merge.sv - per-lane select between an old and a new vector under a lane mask
module vrf_lane_merge
  import vrf_pkg::*;
#(
  parameter int LANES  = VRF_LANES,
  parameter int LANE_W = VRF_LANE_W
) (
  input  logic [LANES*LANE_W-1:0] i_old,
  input  logic [LANES*LANE_W-1:0] i_new,
  input  logic [LANES-1:0]        i_mask,
  output logic [LANES*LANE_W-1:0] o_merged
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign o_merged[lane_lsb(g, LANE_W) +: LANE_W] =
      i_mask[g] ? i_new[lane_lsb(g, LANE_W) +: LANE_W]
                : i_old[lane_lsb(g, LANE_W) +: LANE_W];
  end

endmodule

// File: rtl/vec_reg_file_masked.sv
// rtl/vec_reg_file_masked.sv - vector register file, two registered read ports, lane-masked write, post-reset clear
module vec_reg_file_masked
  import vrf_pkg::*;
#(
  parameter int NUM_REGS = VRF_NUM_REGS,
  parameter int LANES    = VRF_LANES,
  parameter int LANE_W   = VRF_LANE_W,
  localparam int VW      = LANES * LANE_W,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr_1,
  input  logic [AW-1:0]    rd_addr_2,
  output logic [VW-1:0]    data_1,
  output logic [VW-1:0]    data_2,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_dst,
  input  logic [VW-1:0]    wr_data,
  input  logic [LANES-1:0] wr_lane_mask,
  output logic             ready
);

  logic [VW-1:0] r_regs [NUM_REGS];
  logic [AW-1:0] r_cnt;
  vrf_state_e    r_state;
  vrf_state_e    w_state_nxt;

  logic             w_wr_ok;
  logic [LANES-1:0] w_fwd_mask_1;
  logic [LANES-1:0] w_fwd_mask_2;
  logic [VW-1:0]    w_wr_merged;
  logic [VW-1:0]    w_fwd_1;
  logic [VW-1:0]    w_fwd_2;

  assign w_wr_ok      = wr_en && (r_state == VRF_RUN);
  assign w_fwd_mask_1 = (w_wr_ok && (wr_dst == rd_addr_1)) ? wr_lane_mask : '0;
  assign w_fwd_mask_2 = (w_wr_ok && (wr_dst == rd_addr_2)) ? wr_lane_mask : '0;

  // Storage update and both forwarding paths share the same merge so they always agree.
  vrf_lane_merge #(.LANES(LANES), .LANE_W(LANE_W)) u_merge_wr (
    .i_old(r_regs[wr_dst]), .i_new(wr_data), .i_mask(wr_lane_mask), .o_merged(w_wr_merged)
  );
  vrf_lane_merge #(.LANES(LANES), .LANE_W(LANE_W)) u_merge_rd1 (
    .i_old(r_regs[rd_addr_1]), .i_new(wr_data), .i_mask(w_fwd_mask_1), .o_merged(w_fwd_1)
  );
  vrf_lane_merge #(.LANES(LANES), .LANE_W(LANE_W)) u_merge_rd2 (
    .i_old(r_regs[rd_addr_2]), .i_new(wr_data), .i_mask(w_fwd_mask_2), .o_merged(w_fwd_2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= VRF_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == VRF_CLEAR && r_cnt == AW'(NUM_REGS - 1)) begin
      w_state_nxt = VRF_RUN;
    end
  end

  always_comb begin
    ready = 1'b0;
    if (r_state == VRF_RUN) begin
      ready = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == VRF_CLEAR) begin
      r_cnt <= r_cnt + AW'(1);
    end
  end

  // Storage has no reset of its own; the clear sequencer zeroes it before reads are allowed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == VRF_CLEAR) begin
        r_regs[r_cnt] <= '0;
      end else if (wr_en) begin
        r_regs[wr_dst] <= w_wr_merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_1 <= '0;
      data_2 <= '0;
    end else if (rd_en && r_state == VRF_RUN) begin
      data_1 <= w_fwd_1;
      data_2 <= w_fwd_2;
    end
  end

endmodule
